hazard_controller: RTL and testbench

Pipeline stall/flush sequencer for the five-stage core. Watches the ID stage's register reads against EX, the multi-cycle multiplier/divider and the data-memory handshake. It produces the per-stage hold, bubble and flush controls consumed by fetch, the decode stage (`bubbleHold`), execute and memory. It also keeps stall/flush performance counters and a sticky multiplier-timeout flag.

---
 rtl/hazard_controller_pkg.sv | 35 +++
 rtl/hazard_controller_detect.sv | 22 ++
 rtl/hazard_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard sequencer: controller state encoding,
// the bundled stall/flush control bus and the register-match helper.
package hazard_controller_pkg;

   localparam int REG_W = 5;

   // Sequencer state: free-running, waiting on the multiplier, or waiting on data memory.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } HAZ_STATE;

   // The nine per-stage controls, bundled so the pipeline top wires one bus.
   typedef struct packed {
      logic pc_hold;
      logic if_id_hold;
      logic bubble_hold;
      logic ex_hold;
      logic mem_bubble;
      logic mem_hold;
      logic wb_bubble;
      logic flush_if_id;
      logic flush_id_ex;
   } STALL_CTRL;

   // A source read depends on a destination only when it is really read and
   // the destination is not x0 (writes to x0 are discarded).
   function automatic logic reg_match(input logic used,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rd);
      return used & (rs == rd) & (rd != '0);
   endfunction

endpackage

// File: rtl/hazard_controller_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Kept separate so it can be reused
// for CSR read-after-write checks.
module hazard_detect
   import hazard_controller_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_valid,
   input  logic             ex_is_mem_read,
   input  logic [REG_W-1:0] ex_wd,
   output logic             load_use
);

   assign load_use = id_valid & ex_valid & ex_is_mem_read &
                     (reg_match(id_uses_rs1, id_rs1, ex_wd) |
                      reg_match(id_uses_rs2, id_rs2, ex_wd));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer. Controls are combinational from the current
// state and inputs; the state, multiplier watchdog and performance counters
// are registered. Priority: mem wait > mul wait > branch flush > load-use.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MUL_TIMEOUT = 64,
   parameter int CNT_W       = 64
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             idValid,
   input  logic [REG_W-1:0] idRs1,
   input  logic [REG_W-1:0] idRs2,
   input  logic             idUsesRs1,
   input  logic             idUsesRs2,
   input  logic             exValid,
   input  logic             exIsMemRead,
   input  logic [REG_W-1:0] exWd,
   input  logic             exIsMul,
   input  logic             mulDone,
   input  logic             memReq,
   input  logic             memReady,
   input  logic             branchTaken,
   output logic             pcHold,
   output logic             ifIdHold,
   output logic             bubbleHold,
   output logic             exHold,
   output logic             memBubble,
   output logic             memHold,
   output logic             wbBubble,
   output logic             flushIfId,
   output logic             flushIdEx,
   output logic             mulTimeout,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   localparam int             TMO_W    = $clog2(MUL_TIMEOUT + 1);
   // The watchdog fires on the last permitted MUL_WAIT cycle, so the op has
   // been stalled for exactly MUL_TIMEOUT cycles when the release happens.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

   HAZ_STATE         state;
   HAZ_STATE         state_next;
   logic [TMO_W-1:0] tmo_cnt;
   STALL_CTRL        ctrl;

   logic load_use_raw;
   logic mem_cond;
   logic mem_stall;
   logic mul_cond;
   logic tmo_hit;
   logic mul_stall;
   logic tmo_release;
   logic flush;
   logic load_use;

   hazard_detect u_detect (
      .id_valid       (idValid),
      .id_rs1         (idRs1),
      .id_rs2         (idRs2),
      .id_uses_rs1    (idUsesRs1),
      .id_uses_rs2    (idUsesRs2),
      .ex_valid       (exValid),
      .ex_is_mem_read (exIsMemRead),
      .ex_wd          (exWd),
      .load_use       (load_use_raw)
   );

   // Resolve the hazard priority into stage controls and pick the next state.
   always_comb begin
      ctrl        = '0;
      state_next  = RUN;

      mem_cond    = memReq & ~memReady;
      // The completion cycle of a memory wait is still held.
      mem_stall   = mem_cond | (state == MEM_WAIT);
      mul_cond    = exValid & exIsMul & ~mulDone;
      tmo_hit     = (state == MUL_WAIT) & (tmo_cnt == TMO_LAST);
      mul_stall   = mul_cond & ~mem_stall & ~tmo_hit;
      tmo_release = mul_cond & ~mem_stall & tmo_hit;
      // A branch seen during a stall stays asserted (EX is frozen) and is
      // taken on the first free cycle.
      flush       = branchTaken & ~mem_stall & ~mul_stall;
      load_use    = load_use_raw & ~mem_stall & ~mul_stall & ~flush;

      ctrl.pc_hold     = mem_stall | mul_stall | load_use;
      ctrl.if_id_hold  = mem_stall | mul_stall | load_use;
      ctrl.bubble_hold = load_use;
      ctrl.ex_hold     = mem_stall | mul_stall;
      ctrl.mem_bubble  = mul_stall;
      ctrl.mem_hold    = mem_stall;
      ctrl.wb_bubble   = mem_stall;
      ctrl.flush_if_id = flush;
      ctrl.flush_id_ex = flush;

      if (mem_cond) begin
         state_next = MEM_WAIT;
      end else if (mul_stall) begin
         state_next = MUL_WAIT;
      end else begin
         state_next = RUN;
      end
   end

   assign pcHold     = ctrl.pc_hold;
   assign ifIdHold   = ctrl.if_id_hold;
   assign bubbleHold = ctrl.bubble_hold;
   assign exHold     = ctrl.ex_hold;
   assign memBubble  = ctrl.mem_bubble;
   assign memHold    = ctrl.mem_hold;
   assign wbBubble   = ctrl.wb_bubble;
   assign flushIfId  = ctrl.flush_if_id;
   assign flushIdEx  = ctrl.flush_id_ex;

   // State register plus the multiplier watchdog (zero outside MUL_WAIT, so it
   // restarts from zero on every entry) and its sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         tmo_cnt    <= '0;
         mulTimeout <= 1'b0;
      end else begin
         state      <= state_next;
         if (state == MUL_WAIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
         mulTimeout <= mulTimeout | tmo_release;
      end
   end

   // Performance counters: stalled cycles and flushes, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         stallCycles <= stallCycles + {{(CNT_W-1){1'b0}}, ctrl.pc_hold};
         flushCount  <= flushCount  + {{(CNT_W-1){1'b0}}, ctrl.flush_id_ex};
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed scenarios followed by
// randomized traffic, each cycle's expected response predicted from the
// hazard rules and checked by an independent monitor.
module tb_hazard_controller;

   localparam int TIMEOUT = 64;
   localparam int CW      = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          idValid, idUsesRs1, idUsesRs2;
   logic [4:0]    idRs1, idRs2, exWd;
   logic          exValid, exIsMemRead, exIsMul, mulDone;
   logic          memReq, memReady, branchTaken;
   logic          pcHold, ifIdHold, bubbleHold, exHold, memBubble;
   logic          memHold, wbBubble, flushIfId, flushIdEx, mulTimeout;
   logic [CW-1:0] stallCycles, flushCount;

   hazard_controller #(.MUL_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
      .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
      .exValid(exValid), .exIsMemRead(exIsMemRead), .exWd(exWd),
      .exIsMul(exIsMul), .mulDone(mulDone),
      .memReq(memReq), .memReady(memReady), .branchTaken(branchTaken),
      .pcHold(pcHold), .ifIdHold(ifIdHold), .bubbleHold(bubbleHold),
      .exHold(exHold), .memBubble(memBubble), .memHold(memHold),
      .wbBubble(wbBubble), .flushIfId(flushIfId), .flushIdEx(flushIdEx),
      .mulTimeout(mulTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       id_valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       ex_valid;
      logic       ex_ld;
      logic [4:0] wd;
      logic       ex_mul;
      logic       mul_done;
      logic       mem_req;
      logic       mem_ready;
      logic       br;
   } stim_t;

   typedef struct {
      int            cyc;
      logic [8:0]    ctrl;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
      logic          tmo;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   // reference model state, in terms of the rules rather than an FSM
   bit            m_mem_pending;   // a memory wait was open at the end of last cycle
   int            m_mul_waited;    // consecutive cycles the current mul op has stalled
   bit            m_tmo;
   logic [CW-1:0] m_stall;
   logic [CW-1:0] m_flush;

   function automatic stim_t idle_stim();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.id_valid  = 1'($urandom_range(0, 3) != 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.u1        = 1'($urandom_range(0, 1));
      s.u2        = 1'($urandom_range(0, 1));
      s.ex_valid  = 1'($urandom_range(0, 3) != 0);
      s.ex_ld     = 1'($urandom_range(0, 2) == 0);
      s.wd        = 5'($urandom_range(0, 3));
      s.ex_mul    = 1'($urandom_range(0, 3) == 0);
      s.mul_done  = 1'($urandom_range(0, 9) < 4);
      s.mem_req   = 1'($urandom_range(0, 9) < 2);
      s.mem_ready = 1'($urandom_range(0, 1));
      s.br        = 1'($urandom_range(0, 9) == 0);
      return s;
   endfunction

   // One cycle: drive inputs after the falling edge, predict, push, advance the model.
   task automatic drive(input stim_t s, input logic r);
      exp_t e;
      bit   mem_h, mul_want, mul_h, fl, dep, lu, hold;
      @(negedge clk);
      rst         = r;
      idValid     = s.id_valid;   idRs1 = s.rs1;   idRs2 = s.rs2;
      idUsesRs1   = s.u1;         idUsesRs2 = s.u2;
      exValid     = s.ex_valid;   exIsMemRead = s.ex_ld;  exWd = s.wd;
      exIsMul     = s.ex_mul;     mulDone = s.mul_done;
      memReq      = s.mem_req;    memReady = s.mem_ready; branchTaken = s.br;
      #1;
      if (r) begin
         m_mem_pending = 0; m_mul_waited = 0; m_tmo = 0; m_stall = '0; m_flush = '0;
      end
      mem_h    = (s.mem_req && !s.mem_ready) || m_mem_pending;
      mul_want = !mem_h && s.ex_valid && s.ex_mul && !s.mul_done;
      mul_h    = mul_want && (m_mul_waited < TIMEOUT);
      fl       = s.br && !mem_h && !mul_h;
      dep      = s.id_valid && s.ex_valid && s.ex_ld && (s.wd != 0) &&
                 ((s.u1 && s.rs1 == s.wd) || (s.u2 && s.rs2 == s.wd));
      lu       = dep && !mem_h && !mul_h && !fl;
      hold     = mem_h || mul_h || lu;
      e.cyc    = cyc_n;
      e.ctrl   = {hold, hold, lu, mem_h || mul_h, mul_h, mem_h, mem_h, fl, fl};
      e.stall  = m_stall;
      e.flush  = m_flush;
      e.tmo    = m_tmo;
      exp_q.push_back(e);
      if (!r) begin
         if (mul_want && !mul_h) m_tmo = 1;
         m_mul_waited  = mul_h ? m_mul_waited + 1 : 0;
         m_mem_pending = s.mem_req && !s.mem_ready;
         if (hold) m_stall = m_stall + 1;
         if (fl)   m_flush = m_flush + 1;
      end
      cyc_n++;
   endtask

   // Monitor: every cycle the DUT presents a response, compare against the oldest prediction.
   initial begin
      exp_t       e;
      logic [8:0] got;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pcHold, ifIdHold, bubbleHold, exHold, memBubble,
                   memHold, wbBubble, flushIfId, flushIdEx};
            checks++;
            if (got !== e.ctrl) begin
               errors++;
               $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctrl);
            end
            checks++;
            if (stallCycles !== e.stall) begin
               errors++;
               $display("FAIL stallCycles cyc=%0d got=%0d exp=%0d", e.cyc, stallCycles, e.stall);
            end
            checks++;
            if (flushCount !== e.flush) begin
               errors++;
               $display("FAIL flushCount cyc=%0d got=%0d exp=%0d", e.cyc, flushCount, e.flush);
            end
            checks++;
            if (mulTimeout !== e.tmo) begin
               errors++;
               $display("FAIL mulTimeout cyc=%0d got=%b exp=%b", e.cyc, mulTimeout, e.tmo);
            end
         end
      end
   end

   // Stimulus: directed scenarios, random traffic, reset mid-stall, more random traffic.
   initial begin
      stim_t s;
      rst = 1'b1;
      idValid = 0; idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
      exValid = 0; exIsMemRead = 0; exWd = 0; exIsMul = 0; mulDone = 0;
      memReq = 0; memReady = 0; branchTaken = 0;

      drive(idle_stim(), 1'b1);
      drive(idle_stim(), 1'b1);
      drive(idle_stim(), 1'b0);

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      s = idle_stim();
      s.id_valid = 1; s.rs1 = 5; s.u1 = 1; s.rs2 = 1; s.u2 = 1;
      s.ex_valid = 1; s.ex_ld = 1; s.wd = 5;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);
      // same with destination x0: no dependency
      s.wd = 0; s.rs1 = 0;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);

      // multiplier finishing three cycles after issue
      s = idle_stim(); s.ex_valid = 1; s.ex_mul = 1;
      repeat (3) drive(s, 1'b0);
      s.mul_done = 1;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);
      // single-cycle multiply
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);

      // memory wait of four cycles plus the completion cycle
      s = idle_stim(); s.mem_req = 1;
      repeat (4) drive(s, 1'b0);
      s.mem_ready = 1;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);

      // branch arriving during a memory wait
      s = idle_stim(); s.mem_req = 1; s.br = 1;
      repeat (3) drive(s, 1'b0);
      s.mem_ready = 1;
      drive(s, 1'b0);
      s = idle_stim(); s.br = 1;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);

      // branch and load-use in the same cycle
      s = idle_stim();
      s.id_valid = 1; s.rs1 = 7; s.u1 = 1; s.ex_valid = 1; s.ex_ld = 1; s.wd = 7; s.br = 1;
      drive(s, 1'b0);
      drive(idle_stim(), 1'b0);

      // watchdog: multiplier never completes
      s = idle_stim(); s.ex_valid = 1; s.ex_mul = 1;
      repeat (TIMEOUT + 1) drive(s, 1'b0);
      repeat (3) drive(idle_stim(), 1'b0);

      repeat (1500) drive(rand_stim(), 1'b0);

      // reset in the middle of a memory stall
      s = idle_stim(); s.mem_req = 1;
      repeat (2) drive(s, 1'b0);
      drive(idle_stim(), 1'b1);
      drive(idle_stim(), 1'b0);

      repeat (500) drive(rand_stim(), 1'b0);
      drive(idle_stim(), 1'b0);

      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
